// File: rtl/conv_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_5x5
// Description : Streaming 5x5 neighbourhood generator. Buffers the previous
//               four image rows and emits every fully-inside 5x5 window
//               (valid convolution, no padding) one cycle after its
//               bottom-right pixel is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_5x5 #(
  parameter int D = 8,
  parameter int W = 32,
  parameter int H = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic            i_sof,
  input  logic [D-1:0]    i_data,
  output logic            o_valid,
  output logic            o_last,
  output logic [25*D-1:0] o_window
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  localparam logic [CW-1:0] c_col_last = CW'(W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(H - 1);
  localparam logic [CW-1:0] c_col_win  = CW'(4);
  localparam logic [RW-1:0] c_row_win  = RW'(4);

  logic [CW-1:0]  r_col;
  logic [RW-1:0]  r_row;
  // Each entry packs one column of the four previous rows; slot 0 is row r-4.
  logic [4*D-1:0] r_line [W];
  logic [D-1:0]   r_win  [5][5];

  logic [CW-1:0]  w_col;
  logic [RW-1:0]  w_row;
  logic [4*D-1:0] w_lb_rd;
  logic [D-1:0]   w_new_col [5];

  // A start-of-frame pixel is placed at (0,0) no matter where the counters are.
  assign w_col   = i_sof ? '0 : r_col;
  assign w_row   = i_sof ? '0 : r_row;
  assign w_lb_rd = r_line[w_col];

  // Newest window column: four buffered rows above, incoming pixel at the bottom.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_new_col[k] = w_lb_rd[k*D +: D];
    end
    w_new_col[4] = i_data;
  end

  // Raster position of the next accepted pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (w_col == c_col_last) begin
        r_col <= '0;
        r_row <= (w_row == c_row_last) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Line buffers: read-before-write of the same column, rows shifted up by one.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      r_line[w_col] <= {i_data, w_lb_rd[4*D-1:D]};
    end
  end

  // Window register: shift columns left and load the newest column at j=4.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          r_win[i][j] <= '0;
        end
      end
    end else if (i_valid) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_win[i][j] <= r_win[i][j+1];
        end
        r_win[i][4] <= w_new_col[i];
      end
    end
  end

  // Window strobe and end-of-frame marker, gated by the position of the pixel.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      o_valid <= i_valid && (w_row >= c_row_win) && (w_col >= c_col_win);
      o_last  <= i_valid && (w_row == c_row_last) && (w_col == c_col_last);
    end
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_win_row
      for (genvar gj = 0; gj < 5; gj++) begin : g_win_col
        assign o_window[(gi*5+gj)*D +: D] = r_win[gi][gj];
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_window_5x5.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_5x5
// Description : Self-checking bench for conv_window_5x5 (W=8, H=6, D=8).
//               Expected windows come from an image array indexed by the
//               raster position of each accepted pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_5x5;

  localparam int D = 8;
  localparam int W = 8;
  localparam int H = 6;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           valid = 1'b0;
  logic           sof   = 1'b0;
  logic [D-1:0]   data  = '0;
  logic           o_valid;
  logic           o_last;
  logic [25*D-1:0] o_window;

  conv_window_5x5 #(.D(D), .W(W), .H(H)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_sof    (sof),
    .i_data   (data),
    .o_valid  (o_valid),
    .o_last   (o_last),
    .o_window (o_window)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: position of next pixel and the image seen so far.
  int              mr, mc;
  logic [7:0]      img [H][W];
  logic [199:0]    m_hold;
  bit              m_known;
  int              n_win, n_last;
  logic [199:0]    wins [$];

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mr      = 0;
    mc      = 0;
    m_hold  = '0;
    m_known = 1'b1;
  endtask

  task automatic clear_counts();
    n_win  = 0;
    n_last = 0;
    wins.delete();
  endtask

  // One clock: drive inputs, advance the model, check outputs #1 after the edge.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    logic         ev, el;
    logic [199:0] ew;
    valid = v;
    sof   = s;
    data  = d;
    @(posedge clk);
    ev = 1'b0;
    el = 1'b0;
    ew = '0;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 4 && mc >= 4) begin
        ev = 1'b1;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            ew[(i*5+j)*8 +: 8] = img[mr-4+i][mc-4+j];
        m_hold  = ew;
        m_known = 1'b1;
      end else begin
        m_known = 1'b0;
      end
      el = (mr == H-1) && (mc == W-1);
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc = mc + 1;
      end
    end
    #1;
    chk("o_valid", {199'b0, o_valid}, {199'b0, ev});
    chk("o_last", {199'b0, o_last}, {199'b0, el});
    if (ev)
      chk("o_window", o_window, ew);
    else if (!v && m_known)
      chk("window_hold", o_window, m_hold);
    if (o_valid === 1'b1) begin
      n_win++;
      wins.push_back(o_window);
    end
    if (o_last === 1'b1) n_last++;
  endtask

  // Feed n pixels; pixel value is row*16+col unless random data is requested.
  task automatic run_pixels(input int n, input int gap_pct, input bit rnd, input bit sof_first);
    bit         s;
    logic [7:0] d;
    int         g;
    for (int k = 0; k < n; k++) begin
      g = 0;
      while (g < 6 && $urandom_range(99) < gap_pct) begin
        step(1'b0, 1'($urandom), 8'($urandom));
        g++;
      end
      s = sof_first && (k == 0);
      if (rnd)    d = 8'($urandom);
      else if (s) d = 8'h00;
      else        d = 8'(mr*16 + mc);
      step(1'b1, s, d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    // 1. Reset held with random inputs
    #1 rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid = 1'($urandom);
      sof   = 1'($urandom);
      data  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_valid", {199'b0, o_valid}, 200'd0);
      chk("rst_last", {199'b0, o_last}, 200'd0);
      chk("rst_window", o_window, 200'd0);
    end
    valid = 1'b0;
    sof   = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 8'h00);

    // 2. Continuous frame
    clear_counts();
    run_pixels(48, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t2_nwin", 200'(n_win), 200'd8);
    chk("t2_nlast", 200'(n_last), 200'd1);
    if (wins.size() == 8) begin
      chk("t2_first00", {192'b0, wins[0][7:0]},     200'h00);
      chk("t2_first04", {192'b0, wins[0][39:32]},   200'h04);
      chk("t2_first40", {192'b0, wins[0][167:160]}, 200'h40);
      chk("t2_first44", {192'b0, wins[0][199:192]}, 200'h44);
      chk("t2_last00",  {192'b0, wins[7][7:0]},     200'h13);
      chk("t2_last44",  {192'b0, wins[7][199:192]}, 200'h57);
    end

    // 3. Same frame with ~40% idle cycles
    clear_counts();
    run_pixels(48, 40, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t3_nwin", 200'(n_win), 200'd8);
    chk("t3_nlast", 200'(n_last), 200'd1);

    // 4. Abort after 20 pixels with sof, then a full frame
    clear_counts();
    run_pixels(20, 0, 1'b0, 1'b0);
    run_pixels(48, 0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("t4_nwin", 200'(n_win), 200'd8);
    chk("t4_nlast", 200'(n_last), 200'd1);
    if (wins.size() > 0)
      chk("t4_first44", {192'b0, wins[0][199:192]}, 200'h44);

    // 5. Reset pulsed while the counters sit at row 4, col 6
    clear_counts();
    run_pixels(38, 0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", {199'b0, o_valid}, 200'd0);
    chk("t5_rst_window", o_window, 200'd0);
    valid = 1'b1;
    data  = 8'($urandom);
    @(posedge clk);
    #1;
    chk("t5_rst_last", {199'b0, o_last}, 200'd0);
    valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    run_pixels(48, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t5_nwin", 200'(n_win), 200'd8);
    chk("t5_nlast", 200'(n_last), 200'd1);

    // 6. Two frames back-to-back
    clear_counts();
    run_pixels(96, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t6_nwin", 200'(n_win), 200'd16);
    chk("t6_nlast", 200'(n_last), 200'd2);
    if (wins.size() == 16) begin
      chk("t6_f2_00", {192'b0, wins[8][7:0]},     200'h00);
      chk("t6_f2_44", {192'b0, wins[8][199:192]}, 200'h44);
    end

    // 7. Random pixel data with random gaps
    clear_counts();
    run_pixels(48, 30, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    chk("t7_nwin", 200'(n_win), 200'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
